fp_res_collector: RTL

- Downstream stage of the double-precision `a**5 + 0.3*b + c` unit (`challenge`).
- That unit produces `res`/`res_negative`/`err` with a `res_vld` pulse and cannot be stalled. This block captures every result into a FIFO and presents it to a consumer over a valid/ready handshake.
- It snoops `arg_vld` and returns a credit (`credit_ok`) to the issuer, so results in flight plus results stored never exceed FIFO capacity.

---
 rtl/fp_res_collector.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fp_res_collector.sv
// Result collector for the a**5 + 0.3*b + c FP unit: captures every result into a FIFO,
// hands it out over valid/ready and issues credits. Optional stats: FP_RES_COLLECTOR_STATS_EN.
module fp_res_collector #(
  parameter int FLEN = 64,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  input  logic            res_vld,
  input  logic [FLEN-1:0] res,
  input  logic            res_negative,
  input  logic            err,
  output logic            credit_ok,
  output logic            out_vld,
  input  logic            out_ready,
  output logic [FLEN-1:0] out_data,
  output logic            out_negative,
  output logic            out_err,
  output logic [CW-1:0]   in_flight,
  output logic [CW-1:0]   count,
`ifdef FP_RES_COLLECTOR_STATS_EN
  output logic [31:0]     n_res,
  output logic [31:0]     n_err,
  output logic [31:0]     n_neg,
`endif
  output logic            proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = FLEN + 2;

  // Handshake: an entry moves to the consumer in every cycle where out_vld && out_ready
  // are both high at the rising edge; out_ready is ignored while out_vld is low.

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [EW-1:0] head;

  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic          if_zero;
  logic          if_max;
  logic [CW:0]   occupancy;

  assign pop       = out_vld && out_ready;
  assign full      = (count == CW'(DEPTH));
  assign drop      = res_vld && full && !pop;
  assign push      = res_vld && !drop;
  assign if_zero   = (in_flight == '0);
  assign if_max    = (in_flight == '1);

  // Credit is a pure function of registered state, so the issuer sees no input-to-output path.
  assign occupancy = {1'b0, in_flight} + {1'b0, count};
  assign credit_ok = (occupancy < (CW + 1)'(DEPTH));

  assign out_vld      = (count != '0);
  assign head         = mem[rptr];
  assign out_data     = head[EW-1:2];
  assign out_negative = head[1];
  assign out_err      = head[0];

  // Storage is deliberately not reset; contents are only observed when out_vld=1.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {res, res_negative, err};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

  // Saturating in-flight accounting; a simultaneous issue and return cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= '0;
    end else if (arg_vld && !res_vld && !if_max) begin
      in_flight <= in_flight + CW'(1);
    end else if (res_vld && !arg_vld && !if_zero) begin
      in_flight <= in_flight - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if ((arg_vld && !credit_ok) || (res_vld && if_zero) || drop) begin
      proto_err <= 1'b1;
    end
  end

`ifdef FP_RES_COLLECTOR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_res <= '0;
      n_err <= '0;
      n_neg <= '0;
    end else if (pop) begin
      n_res <= n_res + 32'd1;
      if (out_err) begin
        n_err <= n_err + 32'd1;
      end
      if (out_negative) begin
        n_neg <= n_neg + 32'd1;
      end
    end
  end
`endif

endmodule
